// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data/register widths, the
// memory-stage FSM encoding and the word-alignment mask.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port.
// master (stage): dmem_req/we/addr/wdata out; dmem_ack/rdata in.
interface mem_stage_if;
    import mips_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_wb.sv
// MEM/WB pipeline register. i_bubble holds data fields and clears
// control; i_kill captures data but clears control (misaligned op).
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_kill,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic [REG_W-1:0]  i_dest,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [REG_W-1:0]  o_dest,
    output logic [DATA_W-1:0] o_alu,
    output logic [DATA_W-1:0] o_rdata
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_dest       <= '0;
            o_alu        <= '0;
            o_rdata      <= '0;
        end else if (i_bubble) begin
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
        end else begin
            o_reg_write  <= i_reg_write & ~i_kill;
            o_mem_to_reg <= i_mem_to_reg & ~i_kill;
            o_dest       <= i_dest;
            o_alu        <= i_alu;
            o_rdata      <= i_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch decision, variable-latency dmem access
// with timeout, pipeline stall, MEM/WB register, sticky error flag.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              zero,
    input  logic [REG_W-1:0]  destinationRegister,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] readData2,
    mem_stage_if.master       dmem,
    output logic              PCSrc,
    output logic              stall,
    output logic              RegWriteOUT,
    output logic              MemtoRegOUT,
    output logic [REG_W-1:0]  destinationRegisterOUT,
    output logic [DATA_W-1:0] ALUResultOUT,
    output logic [DATA_W-1:0] readDataOUT,
    output logic              memError
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_mem;
    logic              w_misal;
    logic              w_access;
    logic              w_abort;
    logic              w_req;
    logic              w_rd_done;
    logic              w_err_set;
    logic [DATA_W-1:0] w_rdata;

    assign PCSrc    = Branch & zero;

    assign w_mem    = MemRead | MemWrite;
    assign w_misal  = w_mem & (|(ALUResult[1:0] & ALIGN_MASK));
    assign w_access = w_mem & ~w_misal;

    // Abort does not look at ack: the request is withdrawn in
    // this cycle, so an ack here would not belong to it.
    assign w_abort  = (r_state == ACCESS)
                    & (r_cnt == CNT_W'(TIMEOUT - 1));

    // Combinational so a zero-wait memory costs no stall
    assign w_req    = rst_n & w_access & ~w_abort;
    assign stall    = w_req & ~dmem.dmem_ack;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & MemWrite;
    assign dmem.dmem_addr  = w_req ? ALUResult : '0;
    assign dmem.dmem_wdata = w_req ? readData2 : '0;

    // Write wins when both MemRead and MemWrite are set
    assign w_rd_done = w_req & dmem.dmem_ack
                     & MemRead & ~MemWrite;
    assign w_rdata   = w_rd_done ? dmem.dmem_rdata : '0;

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_err_set = w_misal;
        unique case (r_state)
            IDLE: begin
                if (w_req & ~dmem.dmem_ack) begin
                    w_next    = ACCESS;
                    w_cnt_nxt = CNT_W'(1);
                end
            end
            ACCESS: begin
                if (w_abort) begin
                    w_next    = IDLE;
                    w_cnt_nxt = '0;
                    w_err_set = 1'b1;
                end else if (~w_access | dmem.dmem_ack) begin
                    w_next    = IDLE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            memError <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            memError <= memError | w_err_set;
        end
    end

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bubble     (stall),
        .i_kill       (w_misal),
        .i_reg_write  (RegWrite),
        .i_mem_to_reg (MemtoReg),
        .i_dest       (destinationRegister),
        .i_alu        (ALUResult),
        .i_rdata      (w_rdata),
        .o_reg_write  (RegWriteOUT),
        .o_mem_to_reg (MemtoRegOUT),
        .o_dest       (destinationRegisterOUT),
        .o_alu        (ALUResultOUT),
        .o_rdata      (readDataOUT)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=8).
// Inputs change 1ns after posedge; comb outputs sampled at negedge.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Branch, MemRead, MemWrite, MemtoReg, RegWrite, zero;
    logic [4:0]  destinationRegister;
    logic [31:0] ALUResult, readData2;
    logic        PCSrc, stall, RegWriteOUT, MemtoRegOUT, memError;
    logic [4:0]  destinationRegisterOUT;
    logic [31:0] ALUResultOUT, readDataOUT;

    int n_run  = 0;
    int n_fail = 0;

    mem_stage_if dmem ();

    mem_stage #(.TIMEOUT(8), .CNT_W(5)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .Branch                 (Branch),
        .MemRead                (MemRead),
        .MemWrite               (MemWrite),
        .MemtoReg               (MemtoReg),
        .RegWrite               (RegWrite),
        .zero                   (zero),
        .destinationRegister    (destinationRegister),
        .ALUResult              (ALUResult),
        .readData2              (readData2),
        .dmem                   (dmem.master),
        .PCSrc                  (PCSrc),
        .stall                  (stall),
        .RegWriteOUT            (RegWriteOUT),
        .MemtoRegOUT            (MemtoRegOUT),
        .destinationRegisterOUT (destinationRegisterOUT),
        .ALUResultOUT           (ALUResultOUT),
        .readDataOUT            (readDataOUT),
        .memError               (memError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nop();
        Branch = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
        RegWrite = 0; zero = 0; destinationRegister = 0;
        ALUResult = 0; readData2 = 0;
        dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        nop();
        rst_n = 1;
        #2;
        do_reset();

        // Reset state
        chk("rst_rw",   32'(RegWriteOUT), 0);
        chk("rst_alu",  ALUResultOUT, 0);
        chk("rst_rd",   readDataOUT, 0);
        chk("rst_err",  32'(memError), 0);
        chk("rst_stl",  32'(stall), 0);
        chk("rst_st",   32'(dut.r_state), 32'(IDLE));

        // 1: zero-wait load
        MemRead = 1; RegWrite = 1; MemtoReg = 1;
        destinationRegister = 5'd9; ALUResult = 32'h100;
        dmem.dmem_ack = 1; dmem.dmem_rdata = 32'hCAFEF00D;
        mid();
        chk("t1_req",  32'(dmem.dmem_req), 1);
        chk("t1_we",   32'(dmem.dmem_we), 0);
        chk("t1_stl",  32'(stall), 0);
        tick();
        chk("t1_rd",   readDataOUT, 32'hCAFEF00D);
        chk("t1_rw",   32'(RegWriteOUT), 1);
        chk("t1_m2r",  32'(MemtoRegOUT), 1);
        chk("t1_dst",  32'(destinationRegisterOUT), 9);
        chk("t1_st",   32'(dut.r_state), 32'(IDLE));
        nop();

        // 2: store with 3 wait states (RegWrite set to expose bubbles)
        MemWrite = 1; RegWrite = 1; ALUResult = 32'h40;
        readData2 = 32'h12345678;
        dmem.dmem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t2_stl",   32'(stall), 1);
            chk("t2_we",    32'(dmem.dmem_we), 1);
            chk("t2_addr",  dmem.dmem_addr, 32'h40);
            chk("t2_wdata", dmem.dmem_wdata, 32'h12345678);
            tick();
            chk("t2_rw",    32'(RegWriteOUT), 0);
            chk("t2_hold",  ALUResultOUT, 32'h100);
        end
        dmem.dmem_ack = 1;
        mid();
        chk("t2_stl4", 32'(stall), 0);
        chk("t2_req4", 32'(dmem.dmem_req), 1);
        tick();
        chk("t2_alu",  ALUResultOUT, 32'h40);
        chk("t2_rd",   readDataOUT, 0);
        chk("t2_rw1",  32'(RegWriteOUT), 1);
        chk("t2_st",   32'(dut.r_state), 32'(IDLE));
        chk("t2_err",  32'(memError), 0);
        nop();

        // 3: timeout, TIMEOUT=8: 7 stalled request cycles, abort on 8th
        MemRead = 1; RegWrite = 1; ALUResult = 32'h200;
        dmem.dmem_rdata = 32'h55555555;
        for (int i = 1; i <= 8; i++) begin
            mid();
            if (i < 8) begin
                chk("t3_stl", 32'(stall), 1);
                chk("t3_req", 32'(dmem.dmem_req), 1);
            end else begin
                chk("t3_stl8", 32'(stall), 0);
                chk("t3_req8", 32'(dmem.dmem_req), 0);
            end
            tick();
            if (i == 1)
                chk("t3_acc", 32'(dut.r_state), 32'(ACCESS));
        end
        chk("t3_err",  32'(memError), 1);
        chk("t3_rd",   readDataOUT, 0);
        chk("t3_alu",  ALUResultOUT, 32'h200);
        chk("t3_st",   32'(dut.r_state), 32'(IDLE));
        chk("t3_cnt",  32'(dut.r_cnt), 0);
        nop();
        tick();
        chk("t3_stky", 32'(memError), 1);

        do_reset();
        chk("t4_clr",  32'(memError), 0);

        // 4: ALU op then misaligned load
        RegWrite = 1; ALUResult = 32'h77; destinationRegister = 5'd3;
        tick();
        chk("t4_alu",  ALUResultOUT, 32'h77);
        chk("t4_rw0",  32'(RegWriteOUT), 1);
        MemRead = 1; ALUResult = 32'h102; dmem.dmem_ack = 1;
        mid();
        chk("t4_req",  32'(dmem.dmem_req), 0);
        chk("t4_stl",  32'(stall), 0);
        tick();
        chk("t4_err",  32'(memError), 1);
        chk("t4_rw",   32'(RegWriteOUT), 0);
        chk("t4_st",   32'(dut.r_state), 32'(IDLE));
        nop();

        // 5: PCSrc, idle then while stalled
        Branch = 1; zero = 1;
        #1;
        chk("t5_pc1",  32'(PCSrc), 1);
        zero = 0;
        #1;
        chk("t5_pc0",  32'(PCSrc), 0);
        MemRead = 1; RegWrite = 1; ALUResult = 32'h300; zero = 1;
        dmem.dmem_rdata = 32'hA5A5A5A5;
        mid();
        chk("t5_stl",  32'(stall), 1);
        chk("t5_pcs1", 32'(PCSrc), 1);
        tick();
        zero = 0;
        #1;
        chk("t5_stl2", 32'(stall), 1);
        chk("t5_pcs0", 32'(PCSrc), 0);
        dmem.dmem_ack = 1;
        tick();
        chk("t5_rd",   readDataOUT, 32'hA5A5A5A5);
        nop();

        // 6: reset two cycles into an access
        MemRead = 1; RegWrite = 1; ALUResult = 32'h400;
        tick();
        tick();
        chk("t6_acc",  32'(dut.r_state), 32'(ACCESS));
        chk("t6_stl0", 32'(stall), 1);
        rst_n = 0;
        #1;
        chk("t6_req",  32'(dmem.dmem_req), 0);
        chk("t6_stl",  32'(stall), 0);
        chk("t6_alu",  ALUResultOUT, 0);
        chk("t6_rd",   readDataOUT, 0);
        chk("t6_err",  32'(memError), 0);
        tick();
        tick();
        nop();
        rst_n = 1;
        tick();
        chk("t6_st",   32'(dut.r_state), 32'(IDLE));
        chk("t6_cnt",  32'(dut.r_cnt), 0);
        chk("t6_rw",   32'(RegWriteOUT), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
